md_unit: RTL
============

Name: md_unit

Overview:
- Multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes E_MDop and the forwarded operands E_RD1/E_RD2, and owns the architectural HI/LO registers.
- Models multi-cycle mult/div latency with a busy counter; the hazard unit in D uses start/busy to stall MD-class instructions.
- Supplies HI/LO to the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- E_MDop  in  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9–15 treated as none.
- E_RD1  in  32  operand A (rs), already forwarded.
- E_RD2  in  32  operand B (rt), already forwarded.
- E_MD_start  out  1  combinational; 1 when E_MDop ∈ {1,2,3,4}.
- E_MD_busy  out  1  registered; 1 while an operation is in flight.
- E_HI  out  32  architectural HI register.
- E_LO  out  32  architectural LO register.
- E_MD_out  out  32  combinational: E_HI if op=5, E_LO if op=6, else 0.

Behaviour:
- Reset (async, immediate): state=IDLE, count=0, E_MD_busy=0, E_HI=0, E_LO=0, pending result regs=0.
  - Reset asserted mid-operation aborts it; HI/LO stay 0, with no late write after deassert.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1; count is a down-counter sized to max(MULT_CYCLES, DIV_CYCLES).
- IDLE, op∈{1..4} at edge t:
  - Compute the result from E_RD1/E_RD2 sampled at that edge into pending_hi/pending_lo.
  - Load count = MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); go to BUSY.
- BUSY, each edge: count--. At the edge where count goes 1→0: E_HI/E_LO ← pending values, go to IDLE, busy drops.
- Timing: with start in cycle t, busy=1 for cycles t+1..t+N, and new HI/LO are visible from cycle t+N+1.
- mult: {HI,LO} = signed 64-bit product. multu: unsigned 64-bit product.
- div (signed): LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (B=0, ops 3/4): full busy period still runs; HI and LO are left unchanged at completion.
- mthi/mtlo (7/8) in IDLE: E_HI/E_LO ← E_RD1 at the next edge; no busy.
- mfhi/mflo (5/6): no state change.
- Any op arriving while busy=1 is ignored (no restart, no HI/LO write). The D-stage stall guarantees this does not occur in legal flow; verify it is harmless anyway.
- E_MD_start is purely combinational from E_MDop and is asserted even when busy (stall logic ORs start|busy).
- Ops 0 and 9–15: no effect.

Test Plan:
- Reset mid-mult:
  - Stimulus: op=1 with A=3, B=5, then assert reset in the 2nd busy cycle.
  - Required: busy=0 and HI=LO=0 immediately; still 0 after MULT_CYCLES more cycles.
- mult signed:
  - Stimulus: A=0xFFFFFFFE (-2), B=3, op=1 for one cycle, then op=0.
  - Required: busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu:
  - Stimulus: A=0xFFFFFFFF, B=0xFFFFFFFF.
  - Required: HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- div signed:
  - Stimulus 1: A=-7 (0xFFFFFFF9), B=2.
  - Required: busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - Stimulus 2: A=0x80000000, B=0xFFFFFFFF.
  - Required: LO=0x80000000, HI=0.
- divu / divide by zero:
  - Stimulus 1: A=100, B=7, op=4.
  - Required: LO=14, HI=2.
  - Stimulus 2: then A=5, B=0, op=3.
  - Required: busy 10 cycles; LO=14, HI=2 unchanged.
- mthi/mtlo/mf* and op-while-busy:
  - Stimulus 1: op=7 with A=0x1234, then op=8 with A=0x5678.
  - Required: HI=0x1234, LO=0x5678; op=5 gives E_MD_out=0x1234, op=6 gives 0x5678.
  - Stimulus 2: start a mult 2×3, then drive op=8 with A=0xDEAD during busy.
  - Required: ignored; final LO=6, HI=0.

Source files
------------

// File: rtl/md_unit.sv
// rtl/md_unit.sv - EX-stage multiply/divide unit owning the HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDop,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  output logic        E_MD_start,
  output logic        E_MD_busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic [31:0] E_MD_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic [31:0]   pending_hi;
  logic [31:0]   pending_lo;
  logic          pending_wr;

  logic          is_start;
  logic          is_div;
  logic          div_by_zero;
  logic          last_cycle;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic          a_neg;
  logic          b_neg;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   b_mag_safe;
  logic [31:0]   b_u_safe;
  logic [31:0]   sq_mag;
  logic [31:0]   sr_mag;
  logic [31:0]   sdiv_q;
  logic [31:0]   sdiv_r;
  logic [31:0]   udiv_q;
  logic [31:0]   udiv_r;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic [CW-1:0] load_count;

  assign is_start    = (E_MDop == OP_MULT) || (E_MDop == OP_MULTU) ||
                       (E_MDop == OP_DIV)  || (E_MDop == OP_DIVU);
  assign is_div      = (E_MDop == OP_DIV) || (E_MDop == OP_DIVU);
  assign div_by_zero = (E_RD2 == 32'd0);
  assign last_cycle  = (count <= CW'(1));

  // Result datapath: signed division goes through magnitudes so that
  // 0x80000000 / -1 wraps cleanly and the divisor is never zero.
  always_comb begin
    prod_s     = {{32{E_RD1[31]}}, E_RD1} * {{32{E_RD2[31]}}, E_RD2};
    prod_u     = {32'd0, E_RD1} * {32'd0, E_RD2};
    a_neg      = E_RD1[31];
    b_neg      = E_RD2[31];
    a_mag      = a_neg ? (32'd0 - E_RD1) : E_RD1;
    b_mag      = b_neg ? (32'd0 - E_RD2) : E_RD2;
    b_mag_safe = div_by_zero ? 32'd1 : b_mag;
    b_u_safe   = div_by_zero ? 32'd1 : E_RD2;
    sq_mag     = a_mag / b_mag_safe;
    sr_mag     = a_mag % b_mag_safe;
    sdiv_q     = (a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag;
    sdiv_r     = a_neg ? (32'd0 - sr_mag) : sr_mag;
    udiv_q     = E_RD1 / b_u_safe;
    udiv_r     = E_RD1 % b_u_safe;
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    load_count = CW'(MULT_CYCLES);
    case (E_MDop)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = sdiv_r; res_lo = sdiv_q; load_count = CW'(DIV_CYCLES); end
      OP_DIVU:  begin res_hi = udiv_r; res_lo = udiv_q; load_count = CW'(DIV_CYCLES); end
      default:  begin res_hi = 32'd0; res_lo = 32'd0; end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: start leaves IDLE, the final countdown edge returns to it
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (is_start)   state_nxt = S_BUSY;
      S_BUSY:  if (last_cycle) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter, pending result capture, and HI/LO updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_wr <= 1'b0;
      E_HI       <= 32'd0;
      E_LO       <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_start) begin
            count      <= load_count;
            pending_hi <= res_hi;
            pending_lo <= res_lo;
            pending_wr <= !(is_div && div_by_zero);
          end else if (E_MDop == OP_MTHI) begin
            E_HI <= E_RD1;
          end else if (E_MDop == OP_MTLO) begin
            E_LO <= E_RD1;
          end
        end
        S_BUSY: begin
          count <= last_cycle ? '0 : count - CW'(1);
          if (last_cycle && pending_wr) begin
            E_HI <= pending_hi;
            E_LO <= pending_lo;
          end
        end
        default: count <= '0;
      endcase
    end
  end

  // Outputs: start is decoded even while busy so the stall logic can OR it
  always_comb begin
    E_MD_start = is_start;
    E_MD_busy  = (state == S_BUSY);
    case (E_MDop)
      OP_MFHI: E_MD_out = E_HI;
      OP_MFLO: E_MD_out = E_LO;
      default: E_MD_out = 32'd0;
    endcase
  end

endmodule
